// File: rtl/cfg_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfg_sequencer: programmable table that plays configuration entries out
// onto the packed host_controller bus, one entry per hold window.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cfg_sequencer #(
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int INST_W = 48,
  parameter int HOLD_W = 8,
  parameter int HC_W   = INST_W + 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tbl_wen,
  input  logic [AW-1:0]                tbl_addr,
  input  logic [6+HOLD_W+INST_W-1:0]   tbl_data,
  input  logic [AW:0]                  num_entries,
  input  logic                         start,
  input  logic                         abort,
  output logic [HC_W-1:0]              host_controller,
  output logic                         busy,
  output logic                         done,
  output logic                         tbl_err
);

  localparam int          ENT_W   = 6 + HOLD_W + INST_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRIVE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW:0]         num_q, num_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [HC_W-1:0]     hc_q, hc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [ENT_W-1:0]    rd_q;

  // Read address follows idx_d so the entry is already registered in FETCH.
  always_ff @(posedge clk) begin
    if (tbl_wen && !busy_q) begin
      mem[tbl_addr] <= tbl_data;
    end
    rd_q <= mem[idx_d];
  end

  function automatic logic [HC_W-1:0] decode(input logic [ENT_W-1:0] e, input logic first);
    logic [HC_W-1:0]   h;
    logic [1:0]        kind;
    logic [1:0]        row;
    logic [1:0]        col;
    h    = '0;
    kind = e[ENT_W-1 -: 2];
    row  = e[ENT_W-3 -: 2];
    col  = e[ENT_W-5 -: 2];
    case (kind)
      2'd0: begin
        h[INST_W + 8 - int'(row)] = 1'b1;
        h[INST_W + 3 - int'(col)] = 1'b1;
        h[INST_W-1:0]             = e[INST_W-1:0];
      end
      2'd1: begin
        h[INST_W + 8 - int'(row)] = 1'b1;
        h[INST_W + 4]             = 1'b1;
        h[INST_W-1:0]             = e[INST_W-1:0];
      end
      2'd2: begin
        h[INST_W + 9] = 1'b1;
        h[23:0]       = e[23:0];
      end
      default: begin
        h[INST_W + 10] = first;
      end
    endcase
    return h;
  endfunction

  function automatic logic [HOLD_W-1:0] hold_eff(input logic [ENT_W-1:0] e);
    logic [HOLD_W-1:0] h;
    h = e[INST_W +: HOLD_W];
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    hc_d    = '0;
    done_d  = 1'b0;
    err_d   = err_q | (tbl_wen & busy_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = (num_entries > DEPTH_C) ? DEPTH_C : num_entries;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = (num_entries == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d   = hold_eff(rd_q);
        hc_d    = decode(rd_q, 1'b1);
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (cnt_q == HOLD_W'(1)) begin
          if ({1'b0, idx_q} == num_q - (AW+1)'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
          hc_d  = decode(rd_q, 1'b0);
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      hc_d    = '0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      hc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      hc_q    <= hc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign host_controller = hc_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign tbl_err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cfg_sequencer: directed table-driven bench for cfg_sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cfg_sequencer;
  localparam int AW     = 5;
  localparam int INST_W = 48;
  localparam int HOLD_W = 8;
  localparam int HC_W   = INST_W + 11;
  localparam int ENT_W  = 6 + HOLD_W + INST_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tbl_wen = 1'b0;
  logic [AW-1:0]       tbl_addr = '0;
  logic [ENT_W-1:0]    tbl_data = '0;
  logic [AW:0]         num_entries = '0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [HC_W-1:0]     host_controller;
  logic                busy;
  logic                done;
  logic                tbl_err;

  int n_checks = 0;
  int n_err    = 0;

  cfg_sequencer dut (
    .clk(clk), .rst(rst), .tbl_wen(tbl_wen), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .num_entries(num_entries), .start(start), .abort(abort),
    .host_controller(host_controller), .busy(busy), .done(done), .tbl_err(tbl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        kind;
    logic [1:0]        row;
    logic [1:0]        col;
    logic [7:0]        hold;
    logic [47:0]       inst;
    int                drive;
    logic [HC_W-1:0]   exp_first;
    logic [HC_W-1:0]   exp_rest;
  } vec_t;

  vec_t vt[10];
  int   grp_lo[4] = '{0, 5, 8, 9};
  int   grp_n[4]  = '{5, 3, 1, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int addr, input vec_t v);
    tbl_wen  = 1'b1;
    tbl_addr = AW'(addr);
    tbl_data = {v.kind, v.row, v.col, v.hold, v.inst};
    tick();
    tbl_wen  = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_entries = (AW+1)'(n);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic play_group(input int g);
    for (int i = 0; i < grp_n[g]; i++) load(i, vt[grp_lo[g] + i]);
    do_start(grp_n[g]);
    chk("fetch_busy", 64'(busy), 64'd1);
    chk("fetch_hc", 64'(host_controller), 64'd0);
    for (int i = 0; i < grp_n[g]; i++) begin
      for (int k = 0; k < vt[grp_lo[g] + i].drive; k++) begin
        tick();
        chk($sformatf("drive_g%0d_e%0d_c%0d", g, i, k), 64'(host_controller),
            64'((k == 0) ? vt[grp_lo[g] + i].exp_first : vt[grp_lo[g] + i].exp_rest));
      end
      if (i < grp_n[g] - 1) begin
        tick();
        chk($sformatf("gap_g%0d_e%0d", g, i), 64'(host_controller), 64'd0);
      end
    end
    tick();
    chk("done_state_hc", 64'(host_controller), 64'd0);
    chk("done_early", 64'(done), 64'd0);
    tick();
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    tick();
    chk("done_once", 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int seen;
    vt[0] = '{2'd0, 2'd0, 2'd0, 8'd9,   48'h004708078d9f, 9,   {11'b0_0_1000_0_1000, 48'h004708078d9f}, {11'b0_0_1000_0_1000, 48'h004708078d9f}};
    vt[1] = '{2'd0, 2'd0, 2'd1, 8'd9,   48'h00000700002f, 9,   {11'b0_0_1000_0_0100, 48'h00000700002f}, {11'b0_0_1000_0_0100, 48'h00000700002f}};
    vt[2] = '{2'd0, 2'd1, 2'd0, 8'd9,   48'h07074807883f, 9,   {11'b0_0_0100_0_1000, 48'h07074807883f}, {11'b0_0_0100_0_1000, 48'h07074807883f}};
    vt[3] = '{2'd0, 2'd1, 2'd1, 8'd9,   48'h00000070218f, 9,   {11'b0_0_0100_0_0100, 48'h00000070218f}, {11'b0_0_0100_0_0100, 48'h00000070218f}};
    vt[4] = '{2'd0, 2'd2, 2'd0, 8'd9,   48'h07700807054f, 9,   {11'b0_0_0010_0_1000, 48'h07700807054f}, {11'b0_0_0010_0_1000, 48'h07700807054f}};
    vt[5] = '{2'd1, 2'd1, 2'd2, 8'd3,   48'h0000000002c0, 3,   {11'b0_0_0100_1_0000, 48'h0000000002c0}, {11'b0_0_0100_1_0000, 48'h0000000002c0}};
    vt[6] = '{2'd2, 2'd3, 2'd1, 8'd1,   48'hA5A5A5000FFF, 1,   {11'b0_1_0000_0_0000, 48'h000000000FFF}, {11'b0_1_0000_0_0000, 48'h000000000FFF}};
    vt[7] = '{2'd3, 2'd2, 2'd3, 8'd4,   48'h000000001234, 4,   {11'b1_0_0000_0_0000, 48'h0}, {HC_W{1'b0}}};
    vt[8] = '{2'd0, 2'd3, 2'd3, 8'd0,   48'h0000deadbeef, 1,   {11'b0_0_0001_0_0001, 48'h0000deadbeef}, {11'b0_0_0001_0_0001, 48'h0000deadbeef}};
    vt[9] = '{2'd0, 2'd2, 2'd2, 8'd255, 48'hffffffffffff, 255, {11'b0_0_0010_0_0010, 48'hffffffffffff}, {11'b0_0_0010_0_0010, 48'hffffffffffff}};

    tick();
    tick();
    chk("rst_hc", 64'(host_controller), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(tbl_err), 64'd0);
    rst = 1'b0;
    tick();

    for (int g = 0; g < 4; g++) play_group(g);

    // Zero-length sequence.
    do_start(0);
    chk("n0_busy", 64'(busy), 64'd1);
    chk("n0_hc", 64'(host_controller), 64'd0);
    chk("n0_done_early", 64'(done), 64'd0);
    tick();
    chk("n0_done", 64'(done), 64'd1);
    chk("n0_busy_low", 64'(busy), 64'd0);
    chk("n0_hc2", 64'(host_controller), 64'd0);
    tick();

    // Write and start while busy.
    load(0, vt[8]);
    do_start(1);
    tbl_wen  = 1'b1;
    tbl_addr = '0;
    tbl_data = {2'd1, 2'd0, 2'd0, 8'd7, 48'h111111111111};
    start    = 1'b1;
    tick();
    tbl_wen  = 1'b0;
    start    = 1'b0;
    chk("err_set", 64'(tbl_err), 64'd1);
    chk("err_drive", 64'(host_controller), 64'(vt[8].exp_first));
    tick();
    tick();
    chk("busy_start_ignored_done", 64'(done), 64'd1);
    chk("err_sticky", 64'(tbl_err), 64'd1);
    tick();
    do_start(1);
    chk("err_cleared", 64'(tbl_err), 64'd0);
    tick();
    chk("entry_unchanged", 64'(host_controller), 64'(vt[8].exp_first));
    tick();
    tick();
    tick();

    // Abort mid-drive.
    load(0, vt[0]);
    do_start(1);
    tick();
    chk("abort_pre", 64'(host_controller), 64'(vt[0].exp_first));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_hc", 64'(host_controller), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || host_controller != '0) seen++;
    end
    chk("abort_quiet", 64'(seen), 64'd0);

    // Clamp: 63 requested, 32 played, each hold=1.
    for (int i = 0; i < 32; i++) begin
      vec_t v;
      v = '{2'd0, 2'd0, 2'd0, 8'd1, 48'(i), 1, '0, '0};
      load(i, v);
    end
    do_start(63);
    t = 1;
    while (!done && t < 200) begin
      tick();
      t++;
    end
    chk("clamp_done_tick", 64'(t), 64'd66);
    tick();

    // Asynchronous reset mid-drive, then replay.
    load(0, vt[0]);
    do_start(1);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_hc", 64'(host_controller), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    do_start(1);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("replay_c%0d", k), 64'(host_controller), 64'(vt[0].exp_first));
    end
    tick();
    tick();
    chk("replay_done", 64'(done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
